// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default geometry for the instruction fetch path
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, HALTED} state_t;
    localparam int DEPTH_DEF = 256;
    localparam int ADDR_W_DEF = 8;
    localparam logic [31:0] RESET_PC_DEF = 32'd0;
endpackage

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory with a load/write port
module instr_mem_sync
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rdata <= mem[addr];
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencer issuing one memory read at a time and presenting words to decode
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_word,
    output logic [31:0]       inst_pc,
    output logic              busy,
    output logic              fault,
    output logic [15:0]       fetch_count
);
    state_t state;
    logic [31:0] pc;
    logic in_range;

    assign in_range = pc < 32'(DEPTH);
    assign mem_rd_en = state == ISSUE && in_range;
    assign mem_addr = pc[ADDR_W-1:0];
    assign busy = state == ISSUE || state == WAIT || state == HOLD;

    // sequencer: halt beats redirect beats normal flow; a HOLD handshake always counts
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            inst_valid <= 1'b0;
            inst_word <= '0;
            inst_pc <= '0;
            fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (state == HOLD && inst_ready) fetch_count <= fetch_count + 16'd1;
            if (state == IDLE) begin
                if (start) begin
                    state <= ISSUE;
                    pc <= RESET_PC;
                end
            end else if (halt_req) begin
                state <= HALTED;
                inst_valid <= 1'b0;
            end else if (state == HALTED) begin
                if (start) begin
                    state <= ISSUE;
                    pc <= RESET_PC;
                    fault <= 1'b0;
                end
            end else if (redirect_valid) begin
                state <= ISSUE;
                pc <= redirect_pc;
                inst_valid <= 1'b0;
            end else begin
                case (state)
                    ISSUE: begin
                        state <= in_range ? WAIT : HALTED;
                        fault <= !in_range;
                    end
                    WAIT: begin
                        inst_word <= mem_rdata;
                        inst_pc <= pc;
                        inst_valid <= 1'b1;
                        pc <= pc + 32'd1;
                        state <= HOLD;
                    end
                    HOLD: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                            state <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch sequencer with a behavioural memory
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic mem_rd_en;
    logic [7:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic inst_valid;
    logic inst_ready = 1'b0;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic busy;
    logic fault;
    logic [15:0] fetch_count;

    logic [31:0] rom [256];
    logic [63:0] sb [$];
    int n_chk = 0;
    int n_pass = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
        .inst_pc(inst_pc), .busy(busy), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // behavioural synchronous-read memory standing beside the fetch unit
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= rom[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        sb.push_back({pc, 32'h20080001 + pc});
    endtask

    // every handshake must match the oldest expected instruction
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            if (sb.size() == 0) chk("sb_extra", inst_pc, 32'hFFFF_FFFF);
            else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_pc", inst_pc, e[63:32]);
                chk("sb_word", inst_word, e[31:0]);
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_valid"}, 32'(inst_valid), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_word"}, inst_word, 0);
        chk({tag, "_pc"}, inst_pc, 0);
        chk({tag, "_count"}, 32'(fetch_count), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h20080001 + 32'(i);
        step(2);
        chk_reset_values("rst");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) expect_inst(32'(i));
        inst_ready = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        @(negedge clk);
        chk("t1_rd_en", 32'(mem_rd_en), 1);
        chk("t1_addr", 32'(mem_addr), 0);
        step(1);
        @(negedge clk);
        chk("t2_rd_en", 32'(mem_rd_en), 0);
        chk("t2_valid", 32'(inst_valid), 0);
        step(1);
        @(negedge clk);
        chk("t3_valid", 32'(inst_valid), 1);
        chk("t3_word", inst_word, 32'h20080001);
        chk("t3_pc", inst_pc, 0);
        step(3);
        @(negedge clk);
        chk("t6_valid", 32'(inst_valid), 1);
        chk("t6_pc", inst_pc, 1);
        for (int i = 0; i < 60 && fetch_count != 16'd6; i++) step(1);
        inst_ready = 1'b0;
        chk("seq_count", 32'(fetch_count), 6);
        expect_inst(32'd6);
        for (int i = 0; i < 20 && !inst_valid; i++) step(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(inst_valid), 1);
            chk("bp_pc", inst_pc, 6);
            chk("bp_word", inst_word, 32'h20080007);
            chk("bp_rd_en", 32'(mem_rd_en), 0);
            step(1);
        end
        inst_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("bp_next_rd_en", 32'(mem_rd_en), 1);
        chk("bp_next_addr", 32'(mem_addr), 7);
        chk("bp_count", 32'(fetch_count), 7);
        step(1);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        @(negedge clk);
        chk("halt_valid", 32'(inst_valid), 0);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_rd_en", 32'(mem_rd_en), 0);
        step(2);
        @(negedge clk);
        chk("halt_stay_valid", 32'(inst_valid), 0);
        chk("halt_stay_busy", 32'(busy), 0);
        expect_inst(32'd0);
        expect_inst(32'd1);
        expect_inst(32'd40);
        expect_inst(32'd100);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        @(negedge clk);
        chk("rw_wait_valid", 32'(inst_valid), 0);
        chk("rw_wait_pc", inst_pc, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rw_rd_en", 32'(mem_rd_en), 1);
        chk("rw_addr", 32'(mem_addr), 40);
        chk("rw_count", 32'(fetch_count), 9);
        step(2);
        @(negedge clk);
        chk("rh_pc", inst_pc, 40);
        redirect_valid = 1'b1;
        redirect_pc = 32'd100;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rh_count", 32'(fetch_count), 10);
        chk("rh_addr", 32'(mem_addr), 100);
        chk("rh_valid", 32'(inst_valid), 0);
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'd256;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("oor_rd_en", 32'(mem_rd_en), 0);
        chk("oor_count", 32'(fetch_count), 11);
        chk("oor_busy_issue", 32'(busy), 1);
        step(1);
        @(negedge clk);
        chk("oor_fault", 32'(fault), 1);
        chk("oor_busy", 32'(busy), 0);
        chk("oor_halt_rd_en", 32'(mem_rd_en), 0);
        inst_ready = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        @(negedge clk);
        chk("restart_fault", 32'(fault), 0);
        chk("restart_rd_en", 32'(mem_rd_en), 1);
        chk("restart_addr", 32'(mem_addr), 0);
        step(2);
        @(negedge clk);
        chk("restart_valid", 32'(inst_valid), 1);
        chk("restart_pc", inst_pc, 0);
        chk("restart_word", inst_word, 32'h20080001);
        reset = 1'b1;
        step(1);
        chk_reset_values("midrst");
        reset = 1'b0;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
